// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package prefetch_fetch_unit_pkg;

    // Byte distance between consecutive RV32I instructions
    localparam int PC_INCR = 4;

    // Default geometry of the fetch engine
    localparam int DEFAULT_PC_WIDTH   = 9;
    localparam int DEFAULT_XLEN       = 32;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_RESET_PC   = 0;

    // One prefetch entry holds {pc, instruction}
    function automatic int entry_width(input int pc_w, input int xlen);
        return pc_w + xlen;
    endfunction

endpackage

// File: rtl/prefetch_fetch_unit_sync_fifo.sv
// Generic synchronous FIFO with flush, used as the prefetch buffer.
// Latency: a pushed entry becomes visible at the head one cycle later (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign head_dat = mem[rd_ptr];

    // Storage is not reset; occupancy alone decides what is valid
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy update; reset and flush both empty the queue
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Decoupled RV32I fetch engine: issues word reads, buffers {pc, instr}, feeds decode.
// Latency: request to decode_valid is 2 cycles (1 memory + 1 FIFO), also after a redirect.
// Backpressure: decode_ready low fills the FIFO; issue stops when buffered + in-flight reaches depth.
module prefetch_fetch_unit
    import prefetch_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH   = DEFAULT_PC_WIDTH,
    parameter int                  XLEN       = DEFAULT_XLEN,
    parameter int                  FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC),
    localparam int                 CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_request,
    output logic [PC_WIDTH-3:0] imem_address,
    input  logic [XLEN-1:0]     imem_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_address,
    output logic                decode_valid,
    input  logic                decode_ready,
    output logic [XLEN-1:0]     decode_instruction,
    output logic [PC_WIDTH-1:0] decode_pc,
    output logic [CW-1:0]       fifo_count
);

    localparam int EW = entry_width(PC_WIDTH, XLEN);

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic [PC_WIDTH-1:0] issue_pc;
    logic                inflight;
    logic                inflight_epoch;
    logic                epoch;
    logic                redir;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [CW-1:0]       count;
    logic [CW:0]         credit_used;
    logic [EW-1:0]       head;
    logic                redirect_offset_unused;

    // Byte offset of a redirect target is meaningless for word fetch
    assign redirect_offset_unused = ^redirect_address[1:0];

    // A redirect asserted during reset has no effect
    assign redir    = redirect_valid && !reset;
    assign issue_pc = redir ? {redirect_address[PC_WIDTH-1:2], 2'b00} : fetch_pc;

    // Credits: every buffered entry and the one outstanding read hold a FIFO slot
    assign credit_used  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_request = !reset && (redir || (credit_used < (CW + 1)'(FIFO_DEPTH)));
    assign imem_address = issue_pc[PC_WIDTH-1:2];

    // A returning word is kept only if no flush happened since it was issued
    assign push = inflight && (inflight_epoch == epoch) && !redir && !reset;

    assign decode_valid       = !reset && !empty && !redirect_valid;
    assign pop                = decode_valid && decode_ready;
    assign decode_pc          = reset ? '0 : head[EW-1 -: PC_WIDTH];
    assign decode_instruction = reset ? '0 : head[XLEN-1:0];
    assign fifo_count         = reset ? '0 : count;

    // PC advance, flush epoch and outstanding-read bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
        end else begin
            if (redir) begin
                epoch <= ~epoch;
            end
            inflight <= imem_request;
            if (imem_request) begin
                inflight_pc    <= issue_pc;
                inflight_epoch <= redir ? ~epoch : epoch;
                fetch_pc       <= issue_pc + PC_WIDTH'(PC_INCR);
            end
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat ({inflight_pc, imem_data}),
        .pop      (pop),
        .flush    (redir),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // The credit scheme must never let a response arrive at a full buffer
    assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
module tb_prefetch_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_request;
    logic [6:0]  imem_address;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [8:0]  redirect_address;
    logic        decode_valid;
    logic        decode_ready;
    logic [31:0] decode_instruction;
    logic [8:0]  decode_pc;
    logic [2:0]  fifo_count;

    // second instance: wrap-around reset PC
    logic        w_reset;
    logic        w_req;
    logic [6:0]  w_addr;
    logic [31:0] w_data;
    logic        w_redir;
    logic [8:0]  w_redir_addr;
    logic        w_dv;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [8:0]  w_pc;
    logic [2:0]  w_count;

    logic [31:0] mem_words [128];
    int errors = 0;
    int checks = 0;

    prefetch_fetch_unit dut (
        .clock              (clock),
        .reset              (reset),
        .imem_request       (imem_request),
        .imem_address       (imem_address),
        .imem_data          (imem_data),
        .redirect_valid     (redirect_valid),
        .redirect_address   (redirect_address),
        .decode_valid       (decode_valid),
        .decode_ready       (decode_ready),
        .decode_instruction (decode_instruction),
        .decode_pc          (decode_pc),
        .fifo_count         (fifo_count)
    );

    prefetch_fetch_unit #(.RESET_PC(9'h1F8)) u_wrap (
        .clock              (clock),
        .reset              (w_reset),
        .imem_request       (w_req),
        .imem_address       (w_addr),
        .imem_data          (w_data),
        .redirect_valid     (w_redir),
        .redirect_address   (w_redir_addr),
        .decode_valid       (w_dv),
        .decode_ready       (w_ready),
        .decode_instruction (w_instr),
        .decode_pc          (w_pc),
        .fifo_count         (w_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 1-cycle synchronous memories; garbage when no read was issued
    always @(posedge clock) imem_data <= imem_request ? mem_words[imem_address] : $urandom();
    always @(posedge clock) w_data <= w_req ? mem_words[w_addr] : $urandom();

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // leaves the bench one step after a posedge with reset low: cycle 0
    task automatic apply_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_address = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_address = 9'h080;
        decode_ready = 1'b1;
        cyc();
        @(negedge clock);
        checks++; if (imem_request !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_request); end
        checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", decode_valid); end
        checks++; if (decode_instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", decode_instruction); end
        checks++; if (decode_pc !== 9'h0) begin errors++; $display("FAIL rst_pc got %h want 0", decode_pc); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        cyc();
        reset = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clock);
        checks++; if (imem_request !== 1'b1 || imem_address !== 7'h00) begin
            errors++; $display("FAIL rel_req got %b/%h want 1/00", imem_request, imem_address);
        end
        for (int c = 1; c < 3; c++) begin
            cyc();
            @(negedge clock);
            if (c == 1) begin
                checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL rel_c1_valid got %b want 0", decode_valid); end
            end else begin
                checks++; if (decode_valid !== 1'b1 || decode_pc !== 9'h000) begin
                    errors++; $display("FAIL rel_c2_head got %b/%h want 1/000", decode_valid, decode_pc);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [8:0] exp_pc;
        exp_pc = 9'h000;
        decode_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 24; c++) begin
            if (c > 0) cyc();
            @(negedge clock);
            if (c >= 2) begin
                checks++; if (decode_valid !== 1'b1 || decode_pc !== exp_pc) begin
                    errors++; $display("FAIL stream_pc c%0d got %b/%h want 1/%h", c, decode_valid, decode_pc, exp_pc);
                end
                checks++; if (decode_instruction !== mem_words[exp_pc[8:2]]) begin
                    errors++; $display("FAIL stream_instr c%0d got %h want %h", c, decode_instruction, mem_words[exp_pc[8:2]]);
                end
                exp_pc = exp_pc + 9'd4;
            end
        end
    endtask

    task automatic test_stall();
        logic [8:0] exp_pc;
        exp_pc = 9'h000;
        decode_ready = 1'b0;
        apply_reset();
        for (int c = 0; c < 18; c++) begin
            if (c > 0) cyc();
            decode_ready = (c >= 10);
            @(negedge clock);
            if (c >= 2 && c < 10) begin
                checks++; if (decode_valid !== 1'b1 || decode_pc !== 9'h000) begin
                    errors++; $display("FAIL stall_head c%0d got %b/%h want 1/000", c, decode_valid, decode_pc);
                end
            end
            if (c == 9) begin
                checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL stall_count got %0d want 4", fifo_count); end
                checks++; if (imem_request !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", imem_request); end
            end
            if (c >= 10) begin
                checks++; if (decode_valid !== 1'b1 || decode_pc !== exp_pc) begin
                    errors++; $display("FAIL drain_pc c%0d got %b/%h want 1/%h", c, decode_valid, decode_pc, exp_pc);
                end
                exp_pc = exp_pc + 9'd4;
            end
        end
    endtask

    task automatic test_redirect();
        decode_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            redirect_valid = (c == 5);
            redirect_address = 9'h040;
            @(negedge clock);
            if (c == 5) begin
                checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", decode_valid); end
                checks++; if (imem_request !== 1'b1 || imem_address !== 7'h10) begin
                    errors++; $display("FAIL redir_issue got %b/%h want 1/10", imem_request, imem_address);
                end
            end
            if (c == 6) begin
                checks++; if (decode_valid !== 1'b0 || fifo_count !== 3'd0) begin
                    errors++; $display("FAIL redir_squash got %b/%0d want 0/0", decode_valid, fifo_count);
                end
            end
            if (c >= 7) begin
                checks++; if (decode_valid !== 1'b1 || decode_pc !== 9'h040 + 9'(4 * (c - 7))) begin
                    errors++; $display("FAIL redir_pc c%0d got %b/%h want 1/%h", c, decode_valid, decode_pc, 9'h040 + 9'(4 * (c - 7)));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        decode_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            if (c > 0) cyc();
            redirect_valid = (c == 6 || c == 7 || c == 12);
            redirect_address = (c == 6) ? 9'h080 : ((c == 7) ? 9'h100 : 9'h043);
            @(negedge clock);
            if (c == 8) begin
                checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b/%h want 0", decode_valid, decode_pc); end
            end
            if (c == 9 || c == 10) begin
                checks++; if (decode_valid !== 1'b1 || decode_pc !== 9'h100 + 9'(4 * (c - 9))) begin
                    errors++; $display("FAIL b2b_pc c%0d got %b/%h want 1/%h", c, decode_valid, decode_pc, 9'h100 + 9'(4 * (c - 9)));
                end
            end
            if (c == 12) begin
                checks++; if (imem_address !== 7'h10) begin errors++; $display("FAIL unaligned_addr got %h want 10", imem_address); end
            end
            if (c == 14) begin
                checks++; if (decode_valid !== 1'b1 || decode_pc !== 9'h040 || decode_instruction !== mem_words[16]) begin
                    errors++; $display("FAIL unaligned_head got %b/%h/%h want 1/040/%h", decode_valid, decode_pc, decode_instruction, mem_words[16]);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [8:0] exp_pc;
        exp_pc = 9'h1F8;
        w_reset = 1'b1;
        cyc();
        @(negedge clock);
        checks++; if (w_count !== 3'd0 || w_dv !== 1'b0) begin errors++; $display("FAIL wrap_rst got %0d/%b want 0/0", w_count, w_dv); end
        cyc();
        w_reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc();
            @(negedge clock);
            if (c >= 2) begin
                checks++; if (w_dv !== 1'b1 || w_pc !== exp_pc || w_instr !== mem_words[exp_pc[8:2]]) begin
                    errors++; $display("FAIL wrap_pc c%0d got %b/%h want 1/%h", c, w_dv, w_pc, exp_pc);
                end
                exp_pc = exp_pc + 9'd4;
            end
        end
        w_reset = 1'b1;
    endtask

    task automatic test_reset_midstream();
        logic [8:0] exp_pc;
        decode_ready = 1'b1;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc();
            @(negedge clock);
        end
        cyc();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (decode_valid !== 1'b0 || fifo_count !== 3'd0 || imem_request !== 1'b0) begin
            errors++; $display("FAIL mid_rst got %b/%0d/%b want 0/0/0", decode_valid, fifo_count, imem_request);
        end
        exp_pc = 9'h000;
        for (int c = 0; c < 8; c++) begin
            cyc();
            reset = 1'b0;
            @(negedge clock);
            if (c < 2) begin
                checks++; if (decode_valid !== 1'b0 || fifo_count !== 3'd0) begin
                    errors++; $display("FAIL mid_empty c%0d got %b/%0d want 0/0", c, decode_valid, fifo_count);
                end
            end else begin
                checks++; if (decode_valid !== 1'b1 || decode_pc !== exp_pc) begin
                    errors++; $display("FAIL mid_pc c%0d got %b/%h want 1/%h", c, decode_valid, decode_pc, exp_pc);
                end
                exp_pc = exp_pc + 9'd4;
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_pc;
        logic [8:0] prev_pc;
        logic       prev_stall;
        int         pops;
        exp_pc = 9'h000;
        prev_pc = '0;
        prev_stall = 1'b0;
        pops = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (c > 0) cyc();
            decode_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = (c > 2) && ($urandom_range(0, 15) == 0);
            redirect_address = 9'($urandom_range(0, 511));
            @(negedge clock);
            checks++; if (fifo_count > 3'd4) begin errors++; $display("FAIL rnd_count c%0d got %0d want <=4", c, fifo_count); end
            if (redirect_valid) begin
                checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL rnd_redir_valid c%0d got %b want 0", c, decode_valid); end
                exp_pc = {redirect_address[8:2], 2'b00};
            end else begin
                if (prev_stall) begin
                    checks++; if (decode_valid !== 1'b1 || decode_pc !== prev_pc) begin
                        errors++; $display("FAIL rnd_hold c%0d got %b/%h want 1/%h", c, decode_valid, decode_pc, prev_pc);
                    end
                end
                if (decode_valid === 1'b1 && decode_ready) begin
                    checks++; if (decode_pc !== exp_pc || decode_instruction !== mem_words[exp_pc[8:2]]) begin
                        errors++; $display("FAIL rnd_pop c%0d got %h/%h want %h/%h", c, decode_pc, decode_instruction, exp_pc, mem_words[exp_pc[8:2]]);
                    end
                    exp_pc = exp_pc + 9'd4;
                    pops++;
                end
            end
            prev_stall = !redirect_valid && (decode_valid === 1'b1) && !decode_ready;
            prev_pc = decode_pc;
        end
        redirect_valid = 1'b0;
        checks++; if (pops < 100) begin errors++; $display("FAIL rnd_progress got %0d pops want >=100", pops); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_words[i] = $urandom();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_address = '0;
        decode_ready = 1'b0;
        w_reset = 1'b1;
        w_redir = 1'b0;
        w_redir_addr = '0;
        w_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prefetch_fetch_unit.md
Name: prefetch_fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined RV32I core: replaces the bare PC register plus direct instruction-memory hookup with a decoupled fetch engine. It issues word requests to a 1-cycle-latency synchronous instruction memory, buffers returned {pc, instruction} pairs in a prefetch FIFO, and hands them to decode with a valid/ready handshake. Decode stalls and branch/jump redirects are handled without losing or duplicating instructions; wrong-path responses are squashed.

Parameters:
PC_WIDTH, 9, program counter width in bits (byte address); memory word address is PC_WIDTH-2 bits
XLEN, 32, instruction width
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2 (>= 4 required for 1 instr/cycle sustained)
RESET_PC, 0, PC after reset; low two bits must be 0

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
imem_request  out  1  memory read issued this cycle
imem_address  out  PC_WIDTH-2  word address (fetch_pc >> 2)
imem_data  in  XLEN  read data, valid exactly 1 cycle after imem_request
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_address  in  PC_WIDTH  new PC; bits [1:0] ignored (treated as 0)
decode_valid  out  1  head entry valid
decode_ready  in  1  decode accepts head this cycle
decode_instruction  out  XLEN  head instruction
decode_pc  out  PC_WIDTH  head PC
fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy (debug/perf)

Behaviour:
- Reset (synchronous, active-high): fetch_pc <= RESET_PC, FIFO emptied, in-flight flag cleared, epoch <= 0. During reset cycle: imem_request=0, decode_valid=0, decode_instruction=0, decode_pc=0, fifo_count=0. Response to a pre-reset request is discarded.
- Issue rule: imem_request=1 when !reset and (fifo_count + inflight) < FIFO_DEPTH, or on any redirect cycle. On issue: inflight<=1, inflight_pc<=address issued, inflight_epoch<=epoch (post-redirect value); fetch_pc <= issued pc + 4, modulo 2^PC_WIDTH (wraps to 0).
- imem_address = redirect_valid ? redirect_address[PC_WIDTH-1:2] : fetch_pc[PC_WIDTH-1:2] (zero-bubble redirect issue).
- Response: cycle after an issue, {inflight_pc, imem_data} is pushed iff inflight_epoch == epoch and no redirect this cycle; otherwise dropped. Credit rule guarantees push never hits a full FIFO; push to full is an assertion failure.
- Pop: when decode_valid && decode_ready && !redirect_valid. Push and pop same cycle: count unchanged. No bypass: an entry is visible to decode the cycle after push.
- decode_valid = !empty && !redirect_valid. Head outputs held stable while decode_valid && !decode_ready.
- Redirect (redirect_valid=1): FIFO count <= 0 (pointers reset), epoch toggles, pending response squashed, request for redirect_address issued same cycle, fetch_pc <= redirect_address(word-aligned) + 4. Redirect wins over pop, push and reset-free issue limits. Redirect during reset ignored.
- Latency: reset deasserted at cycle 0 -> request at 0, decode_valid with RESET_PC at 2. Redirect at cycle t -> decode_valid with redirect PC at t+2.
- Back-to-back redirects (t, t+1): only the t+1 target reaches decode, at t+3.
- Throughput: FIFO_DEPTH>=4 with decode_ready held high yields one instruction per cycle after the first two cycles.

Decomposition:
- Shared header (alongside riscv.h): PC increment constant (4), FIFO entry width (PC_WIDTH+XLEN) macro, RESET_PC default.
- One sub-module: sync_fifo (parametrised WIDTH, DEPTH; push, pop, flush, full, empty, count; synchronous active-high reset, registered storage, no bypass). Epoch/inflight tracking and PC logic stay in prefetch_fetch_unit.

Test Plan:
- Reset release, decode_ready=1, memory returns word = address: decode_pc 0,4,8,... from cycle 2, one per cycle, decode_instruction = pc>>2; no gaps.
- decode_ready=0 for 10 cycles after start: fifo_count saturates at 4, imem_request drops to 0, head stays pc=0; on release pcs 0..12 drain in order, none lost or duplicated.
- Redirect to 0x40 at cycle 5 with FIFO non-empty and a request in flight: decode_valid=0 at 5, squashed response not pushed, decode_pc=0x40 at cycle 7, then 0x44.
- Redirect to 0x80 at t and 0x100 at t+1: 0x80 never presented; decode_pc=0x100 at t+3. Redirect to 0x43 fetches 0x40.
- PC wrap: RESET_PC=0x1F8 (PC_WIDTH=9): sequence 0x1F8, 0x1FC, 0x000, 0x004.
- Reset asserted mid-stream with request in flight: next cycle decode_valid=0, fifo_count=0; after release sequence restarts at RESET_PC, stale response never appears.
